// File: rtl/cpu_bus_driver_if.sv
`default_nettype none
//==============================================================================
// Module      : cpu_bus_driver_if
// Description : Request/response and BRAM bus signal bundle for cpu_bus_driver.
// Revision    : 1.0 - initial release
//==============================================================================
interface cpu_bus_driver_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [1:0]  REQ_SELECT;
    logic [13:0] REQ_ADDR;
    logic [15:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [15:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        BUS_EN;
    logic        BUS_WE;
    logic        BUS_RD;
    logic        BUS_RDWR;
    logic [1:0]  BUS_SELECT;
    logic [13:0] BUS_ADDR;
    logic [15:0] BUS_DATA_OUT;
    logic        BUS_DATA_OE;
    logic [15:0] BUS_DATA_IN;

    // Driver side: accepts requests and masters the BRAM bus.
    modport master (
        input  REQ_VALID, REQ_WE, REQ_SELECT, REQ_ADDR, REQ_WDATA, BUS_DATA_IN,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        output BUS_EN, BUS_WE, BUS_RD, BUS_RDWR, BUS_SELECT, BUS_ADDR,
        output BUS_DATA_OUT, BUS_DATA_OE
    );

    // Environment side: requester plus the memory/pad model.
    modport slave (
        output REQ_VALID, REQ_WE, REQ_SELECT, REQ_ADDR, REQ_WDATA, BUS_DATA_IN,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        input  BUS_EN, BUS_WE, BUS_RD, BUS_RDWR, BUS_SELECT, BUS_ADDR,
        input  BUS_DATA_OUT, BUS_DATA_OE
    );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_driver.sv
`default_nettype none
//==============================================================================
// Module      : cpu_bus_driver
// Description : Sequences one BRAM access per request through SETUP/STROBE/HOLD
//               phases with fully registered bus outputs.
// Macro       : CPU_BUS_DRIVER_READ_EN - enables read cycles; without it reads
//               are answered immediately with RSP_ERR.
// Revision    : 1.0 - initial release
//==============================================================================
module cpu_bus_driver #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  wire              CLK,
    input  wire              RESET_N,
    cpu_bus_driver_if.master drv
);

`ifdef CPU_BUS_DRIVER_READ_EN
    localparam bit c_read_en = 1'b1;
`else
    localparam bit c_read_en = 1'b0;
`endif

    localparam logic [3:0] c_setup_load  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] c_strobe_load = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] c_hold_load   = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_bus_en;
    logic        r_bus_we;
    logic        r_bus_rd;
    logic        r_bus_rdwr;
    logic [1:0]  r_bus_select;
    logic [13:0] r_bus_addr;
    logic [15:0] r_bus_dout;
    logic        r_bus_oe;
    logic [15:0] r_rd_capture;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [15:0] r_rsp_rdata;

    logic        w_ready;
    logic        w_accept;
    logic        w_reject;
    logic        w_start;
    logic        w_last;
    logic        w_done;
    logic        w_cap;
    logic        w_we_nxt;
    logic        w_active_nxt;

    assign w_ready  = (r_state == IDLE) && RESET_N;
    assign w_accept = drv.REQ_VALID && w_ready;
    // A read in a write-only build is consumed without touching the bus.
    assign w_reject = w_accept && !drv.REQ_WE && !c_read_en;
    assign w_start  = w_accept && !w_reject;
    assign w_last   = (r_cnt == 4'd0);
    assign w_done   = (r_state == HOLD) && w_last;
    assign w_cap    = (r_state == STROBE) && w_last && r_bus_rdwr && c_read_en;

    // RDWR register doubles as the latched transfer direction.
    assign w_we_nxt     = w_start ? drv.REQ_WE : !r_bus_rdwr;
    assign w_active_nxt = (w_state_nxt != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = c_setup_load;
                end
            end
            SETUP: begin
                if (w_last) begin
                    w_state_nxt = STROBE;
                    w_cnt_nxt   = c_strobe_load;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            STROBE: begin
                if (w_last) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = c_hold_load;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            HOLD: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Bus outputs are decoded from the next state so they line up with the phase.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bus_en     <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_rd     <= 1'b0;
            r_bus_oe     <= 1'b0;
            r_bus_rdwr   <= 1'b1;
            r_bus_select <= 2'd0;
            r_bus_addr   <= 14'd0;
            r_bus_dout   <= 16'd0;
        end else begin
            r_bus_en <= w_active_nxt;
            r_bus_we <= (w_state_nxt == STROBE) && w_we_nxt;
            r_bus_rd <= (w_state_nxt == STROBE) && !w_we_nxt;
            r_bus_oe <= w_active_nxt && w_we_nxt;
            if (w_start) begin
                r_bus_rdwr   <= !drv.REQ_WE;
                r_bus_select <= drv.REQ_SELECT;
                r_bus_addr   <= drv.REQ_ADDR;
                r_bus_dout   <= drv.REQ_WDATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_capture <= 16'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= 16'd0;
        end else begin
            if (w_cap) begin
                r_rd_capture <= drv.BUS_DATA_IN;
            end
            r_rsp_valid <= w_done || w_reject;
            r_rsp_err   <= w_reject;
            if (w_reject) begin
                r_rsp_rdata <= 16'd0;
            end else if (w_done && r_bus_rdwr) begin
                r_rsp_rdata <= r_rd_capture;
            end
        end
    end

    assign drv.REQ_READY    = w_ready;
    assign drv.RSP_VALID    = r_rsp_valid;
    assign drv.RSP_RDATA    = r_rsp_rdata;
    assign drv.RSP_ERR      = r_rsp_err;
    assign drv.BUS_EN       = r_bus_en;
    assign drv.BUS_WE       = r_bus_we;
    assign drv.BUS_RD       = r_bus_rd;
    assign drv.BUS_RDWR     = r_bus_rdwr;
    assign drv.BUS_SELECT   = r_bus_select;
    assign drv.BUS_ADDR     = r_bus_addr;
    assign drv.BUS_DATA_OUT = r_bus_dout;
    assign drv.BUS_DATA_OE  = r_bus_oe;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_driver.sv
`default_nettype none
//==============================================================================
// Module      : tb_cpu_bus_driver
// Description : Self-checking bench for cpu_bus_driver; instance 0 uses default
//               timing, instance 1 uses SETUP=3/STROBE=1/HOLD=2.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_cpu_bus_driver;

    localparam int S1 = 1, T1 = 2, H1 = 1;
    localparam int S2 = 3, T2 = 1, H2 = 2;
`ifdef CPU_BUS_DRIVER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_driver_if bif1 ();
    cpu_bus_driver_if bif2 ();

    cpu_bus_driver #(.SETUP_CYCLES(S1), .STROBE_CYCLES(T1), .HOLD_CYCLES(H1))
        dut1 (.CLK(clk), .RESET_N(rst_n), .drv(bif1));
    cpu_bus_driver #(.SETUP_CYCLES(S2), .STROBE_CYCLES(T2), .HOLD_CYCLES(H2))
        dut2 (.CLK(clk), .RESET_N(rst_n), .drv(bif2));

    typedef struct packed {
        logic        ready;
        logic        rsp_valid;
        logic        rsp_err;
        logic [15:0] rsp_rdata;
        logic        en;
        logic        we;
        logic        rd;
        logic        rdwr;
        logic [1:0]  sel;
        logic [13:0] addr;
        logic [15:0] dout;
        logic        oe;
    } obs_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_rdata [0:1];

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0) begin
            o = '{bif1.REQ_READY, bif1.RSP_VALID, bif1.RSP_ERR, bif1.RSP_RDATA,
                  bif1.BUS_EN, bif1.BUS_WE, bif1.BUS_RD, bif1.BUS_RDWR,
                  bif1.BUS_SELECT, bif1.BUS_ADDR, bif1.BUS_DATA_OUT, bif1.BUS_DATA_OE};
        end else begin
            o = '{bif2.REQ_READY, bif2.RSP_VALID, bif2.RSP_ERR, bif2.RSP_RDATA,
                  bif2.BUS_EN, bif2.BUS_WE, bif2.BUS_RD, bif2.BUS_RDWR,
                  bif2.BUS_SELECT, bif2.BUS_ADDR, bif2.BUS_DATA_OUT, bif2.BUS_DATA_OE};
        end
        return o;
    endfunction

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk16(tag, {15'd0, obs}, {15'd0, exp});
    endtask

    task automatic drive_req(input int which, input logic v, input logic we,
                             input logic [1:0] sel, input logic [13:0] addr,
                             input logic [15:0] wd);
        if (which == 0) begin
            bif1.REQ_VALID = v; bif1.REQ_WE = we; bif1.REQ_SELECT = sel;
            bif1.REQ_ADDR = addr; bif1.REQ_WDATA = wd;
        end else begin
            bif2.REQ_VALID = v; bif2.REQ_WE = we; bif2.REQ_SELECT = sel;
            bif2.REQ_ADDR = addr; bif2.REQ_WDATA = wd;
        end
    endtask

    task automatic junk_req(input int which, input logic v);
        drive_req(which, v, 1'($urandom), 2'($urandom), 14'($urandom), 16'($urandom));
    endtask

    task automatic drive_din(input int which, input logic [15:0] d);
        if (which == 0) bif1.BUS_DATA_IN = d;
        else            bif2.BUS_DATA_IN = d;
    endtask

    task automatic chk_reset(input int which);
        obs_t o;
        o = sample(which);
        chk1("rst_ready", o.ready, 1'b0);
        chk1("rst_rsp_valid", o.rsp_valid, 1'b0);
        chk1("rst_rsp_err", o.rsp_err, 1'b0);
        chk16("rst_rsp_rdata", o.rsp_rdata, 16'd0);
        chk1("rst_bus_en", o.en, 1'b0);
        chk1("rst_bus_we", o.we, 1'b0);
        chk1("rst_bus_rd", o.rd, 1'b0);
        chk1("rst_bus_rdwr", o.rdwr, 1'b1);
        chk16("rst_bus_select", {14'd0, o.sel}, 16'd0);
        chk16("rst_bus_addr", {2'd0, o.addr}, 16'd0);
        chk16("rst_bus_dout", o.dout, 16'd0);
        chk1("rst_bus_oe", o.oe, 1'b0);
    endtask

    task automatic idle_cycles(input int which, input int n);
        obs_t o;
        junk_req(which, 1'b0);
        for (int g = 0; g < n; g++) begin
            @(negedge clk);
            o = sample(which);
            chk1("idle_bus_en", o.en, 1'b0);
            chk1("idle_rsp_valid", o.rsp_valid, 1'b0);
            chk1("idle_ready", o.ready, 1'b1);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the
    // completion cycle. Expected waveform derived from cycle offsets after accept.
    task automatic txn(input int which, input logic wr, input logic [1:0] sel,
                       input logic [13:0] addr, input logic [15:0] wdata,
                       input logic [15:0] din, input bit keep_valid);
        int s, t, l;
        obs_t o;
        logic [15:0] exp_rd;
        s = (which == 0) ? S1 : S2;
        t = (which == 0) ? T1 : T2;
        l = s + t + ((which == 0) ? H1 : H2);
        drive_req(which, 1'b1, wr, sel, addr, wdata);
        o = sample(which);
        chk1("ready_at_issue", o.ready, 1'b1);
        @(posedge clk);
        #1;
        junk_req(which, keep_valid);
        if (!wr && !READ_EN) begin
            @(negedge clk);
            o = sample(which);
            chk1("err_rsp_valid", o.rsp_valid, 1'b1);
            chk1("err_rsp_err", o.rsp_err, 1'b1);
            chk16("err_rsp_rdata", o.rsp_rdata, 16'd0);
            chk1("err_bus_en", o.en, 1'b0);
            chk1("err_bus_rd", o.rd, 1'b0);
            chk1("err_ready", o.ready, 1'b1);
            exp_rdata[which] = 16'd0;
        end else begin
            exp_rd = wr ? exp_rdata[which] : din;
            for (int k = 1; k <= l + 1; k++) begin
                @(negedge clk);
                o = sample(which);
                chk1("bus_en", o.en, k <= l);
                chk1("bus_we", o.we, wr && (k > s) && (k <= s + t));
                chk1("bus_rd", o.rd, !wr && (k > s) && (k <= s + t));
                chk1("bus_data_oe", o.oe, wr && (k <= l));
                chk1("req_ready", o.ready, k == l + 1);
                chk1("rsp_valid", o.rsp_valid, k == l + 1);
                chk1("rsp_err", o.rsp_err, 1'b0);
                chk16("rsp_rdata", o.rsp_rdata, (k == l + 1) ? exp_rd : exp_rdata[which]);
                if (k <= l) begin
                    chk1("bus_rdwr", o.rdwr, !wr);
                    chk16("bus_select", {14'd0, o.sel}, {14'd0, sel});
                    chk16("bus_addr", {2'd0, o.addr}, {2'd0, addr});
                    if (wr) chk16("bus_data_out", o.dout, wdata);
                    junk_req(which, keep_valid);
                end
                // Only the last strobe cycle carries the real read data.
                drive_din(which, (k == s + t) ? din : 16'($urandom));
            end
            exp_rdata[which] = exp_rd;
        end
    endtask

    initial begin
        obs_t        o;
        int          which;
        logic        wr;
        logic [1:0]  sel;
        logic [13:0] addr;
        logic [15:0] wd;
        logic [15:0] din;

        exp_rdata[0] = 16'd0;
        exp_rdata[1] = 16'd0;
        drive_req(0, 1'b0, 1'b0, 2'd0, 14'd0, 16'd0);
        drive_req(1, 1'b0, 1'b0, 2'd0, 14'd0, 16'd0);
        drive_din(0, 16'd0);
        drive_din(1, 16'd0);

        // Power-on reset
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed write and read with default timing
        txn(0, 1'b1, 2'd1, 14'h0123, 16'hBEEF, 16'h0000, 1'b0);
        idle_cycles(0, 1);
        txn(0, 1'b0, 2'd2, 14'h3FFF, 16'h1234, 16'hA5A5, 1'b0);
        idle_cycles(0, 2);

        // Two writes with REQ_VALID held high throughout
        txn(0, 1'b1, 2'd0, 14'h0010, 16'h1111, 16'h0000, 1'b1);
        txn(0, 1'b1, 2'd3, 14'h0020, 16'h2222, 16'h0000, 1'b0);
        idle_cycles(0, 1);

        // Reset dropped in cycle 2 of a write
        drive_req(0, 1'b1, 1'b1, 2'd1, 14'h0ABC, 16'hCAFE);
        @(posedge clk);
        #1;
        junk_req(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        o = sample(0);
        chk1("pre_reset_bus_we", o.we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        exp_rdata[0] = 16'd0;
        exp_rdata[1] = 16'd0;
        @(negedge clk);
        chk_reset(0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            o = sample(0);
            chk1("post_reset_rsp_valid", o.rsp_valid, 1'b0);
            chk1("post_reset_bus_en", o.en, 1'b0);
            chk1("post_reset_ready", o.ready, 1'b1);
        end

        // Non-default timing instance
        txn(1, 1'b1, 2'd1, 14'h0155, 16'h5A5A, 16'h0000, 1'b0);
        idle_cycles(1, 1);
        txn(1, 1'b0, 2'd3, 14'h2AAA, 16'h0000, 16'h3C3C, 1'b0);
        idle_cycles(1, 1);

        // Randomized traffic on both instances
        for (int i = 0; i < 48; i++) begin
            which = ($urandom_range(0, 3) == 0) ? 1 : 0;
            wr    = 1'($urandom);
            sel   = 2'($urandom);
            addr  = 14'($urandom);
            wd    = 16'($urandom);
            din   = 16'($urandom);
            txn(which, wr, sel, addr, wd, din, 1'b0);
            idle_cycles(which, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_bus_driver.md
CPU_BUS_DRIVER -- requirements
Module: cpu_bus_driver

Interface
- REQ-001 SHALL have parameter SETUP_CYCLES, default 1: bus cycles of address/EN setup before the strobe, legal 1..15.
- REQ-002 SHALL have parameter STROBE_CYCLES, default 2: bus cycles WE/RD are asserted, legal 1..15.
- REQ-003 SHALL have parameter HOLD_CYCLES, default 1: bus cycles of address/data hold after the strobe, legal 1..15.
- REQ-004 SHALL have one clock and an asynchronous, active-low reset, named CLK and RESET_N.
- REQ-005 SHALL have ports:
  - CLK  in  1  sole clock, rising edge.
  - RESET_N  in  1  asynchronous active-low reset.
  - REQ_VALID  in  1  request present.
  - REQ_READY  out  1  request accepted when REQ_VALID is also high.
  - REQ_WE  in  1  1 = write, 0 = read.
  - REQ_SELECT  in  2  BRAM select.
  - REQ_ADDR  in  14  BRAM word address.
  - REQ_WDATA  in  16  write data.
  - RSP_VALID  out  1  one-cycle completion pulse.
  - RSP_RDATA  out  16  read data; valid with RSP_VALID.
  - RSP_ERR  out  1  request rejected; valid with RSP_VALID.
  - BUS_EN  out  1  chip enable (CS active-high).
  - BUS_WE  out  1  write strobe.
  - BUS_RD  out  1  read strobe.
  - BUS_RDWR  out  1  1 = read cycle, 0 = write cycle.
  - BUS_SELECT  out  2  driven BRAM select.
  - BUS_ADDR  out  14  driven word address.
  - BUS_DATA_OUT  out  16  write data to the tristate pad.
  - BUS_DATA_OE  out  1  pad output enable.
  - BUS_DATA_IN  in  16  read data from the pad.

Function
- REQ-006 SHALL implement FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE, with a 4-bit down-counter per phase.
- REQ-007 SHALL assert REQ_READY only in IDLE; a handshake (REQ_VALID & REQ_READY) latches WE/SELECT/ADDR/WDATA and enters SETUP on the next edge.
- REQ-008 SHALL hold each phase for exactly its parameter's number of cycles; one transaction occupies 1 + SETUP + STROBE + HOLD cycles, including the accepting IDLE cycle.
- REQ-009 SHALL drive BUS_EN high, and BUS_SELECT/BUS_ADDR/BUS_RDWR stable, throughout SETUP, STROBE and HOLD, and low in IDLE.
- REQ-010 SHALL, for writes, drive BUS_DATA_OE high and BUS_DATA_OUT stable across SETUP..HOLD, and assert BUS_WE only in STROBE.
- REQ-011 SHALL, for reads, keep BUS_DATA_OE low, assert BUS_RD only in STROBE, and register BUS_DATA_IN on the last STROBE cycle.
- REQ-012 SHALL pulse RSP_VALID for one cycle, the first IDLE cycle after HOLD, for both reads and writes; RSP_RDATA SHALL hold its value until the next read completes.
- REQ-013 SHALL, on back-to-back requests, deassert BUS_EN for at least the one accepting IDLE cycle between transactions.
- REQ-014 SHALL register all bus outputs, so no combinational path exists from REQ_* to BUS_*.
- REQ-015 SHALL ignore REQ_* changes outside the accepting cycle.

Reset
- REQ-016 SHALL, on RESET_N low (any state, including mid-transaction), immediately force state IDLE and drive BUS_EN/WE/RD/DATA_OE=0, BUS_RDWR=1, BUS_ADDR=0, BUS_SELECT=0, BUS_DATA_OUT=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0.
- REQ-017 SHALL emit no RSP_VALID for a transaction aborted by reset, and SHALL hold REQ_READY low while RESET_N is low.

Configuration
- REQ-018 SHALL gate read support with macro CPU_BUS_DRIVER_READ_EN.
- REQ-019 SHALL, with CPU_BUS_DRIVER_READ_EN defined, execute reads per REQ-011; RSP_ERR stays 0.
- REQ-020 SHALL, without CPU_BUS_DRIVER_READ_EN, accept a read request but generate no bus activity (BUS_EN stays 0), and pulse RSP_VALID with RSP_ERR=1 and RSP_RDATA=0 on the cycle after acceptance.

Verification (defaults; acceptance in cycle 0)
- REQ-021 SHALL cover a write of SELECT=1, ADDR=0x0123, WDATA=0xBEEF -> BUS_EN=1 in cycles 1-4, BUS_WE=1 in cycles 2-3, OE=1 in cycles 1-4, RSP_VALID in cycle 5.
- REQ-022 SHALL cover a read of ADDR=0x3FFF with BUS_DATA_IN=0xA5A5 in cycle 3 -> BUS_RD=1 in cycles 2-3, RSP_RDATA=0xA5A5 with RSP_VALID in cycle 5.
- REQ-023 SHALL cover REQ_VALID held high for two writes -> second accepted in cycle 5, BUS_EN low in cycle 5, high in cycles 6-9.
- REQ-024 SHALL cover RESET_N dropped in cycle 2 of a write -> all BUS_* at reset values the same cycle, no RSP_VALID, REQ_READY=1 after release.
- REQ-025 SHALL cover a read built without CPU_BUS_DRIVER_READ_EN -> BUS_EN never high, RSP_VALID=1 with RSP_ERR=1 in cycle 1.
- REQ-026 SHALL cover SETUP=3, STROBE=1, HOLD=2 -> BUS_WE only in cycle 4, RSP_VALID in cycle 7.
